mips_instr_encoder: RTL and testbench
=====================================

// Module: mips_instr_encoder
// PURPOSE
//  Encoder counterpart of the control decoder: turns symbolic instruction requests (kind + register/immediate
//  fields) into 32-bit MIPS words and writes them sequentially into instruction memory. Sits between the
//  testbench/boot loader and the imem write port; programs the datapath before the CPU is released.
// PARAMETERS
//  ADDR_W     32   width of imem byte address
//  BASE_ADDR  0    byte address of first written word
//  MAX_WORDS  256  words per program; reaching it forces DONE
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  start        in   1       pulse: begin new program load
//  req_valid    in   1       request present
//  req_ready    out  1       encoder accepts request this cycle
//  req_kind     in   4       0 ADD,1 SUB,2 AND,3 OR,4 SLT,5 ADDI,6 LW,7 SW,8 BEQ,9 J,F END; A-E illegal
//  req_rs/rt/rd in   5 each  register fields
//  req_imm      in   16      immediate / branch offset (I-type)
//  req_target   in   26      jump target (J)
//  imem_we      out  1       write strobe, held until imem_ack
//  imem_addr    out  ADDR_W  byte address of current word
//  imem_wdata   out  32      encoded instruction
//  imem_ack     in   1       memory accepted write this cycle
//  busy         out  1       state != IDLE and != DONE
//  done         out  1       program load complete (level)
//  err_illegal  out  1       sticky: illegal kind seen since start
//  word_count   out  9       words written since start
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; all outputs 0; imem_addr=BASE_ADDR; word_count=0.
//  FSM IDLE -> ACCEPT on start; DONE -> ACCEPT on start; start ignored in ACCEPT/WRITE.
//   On start: imem_addr<=BASE_ADDR, word_count<=0, err_illegal<=0, done<=0.
//  ACCEPT: req_ready=1. On req_valid:
//   legal kind 0-9: imem_wdata<=encoded word, imem_we<=1, -> WRITE (1 cycle accept-to-strobe latency).
//   END (F): -> DONE, nothing written. Illegal (A-E): err_illegal<=1, word dropped, stay ACCEPT.
//  WRITE: req_ready=0; imem_we/addr/wdata stable until imem_ack. On ack: imem_we<=0, imem_addr+=4,
//   word_count+=1; if new count==MAX_WORDS -> DONE else -> ACCEPT. Ack in the first WRITE cycle is legal.
//  DONE: done=1, req_ready=0, imem_we=0; holds until start.
//  Encoding (shamt=0 always):
//   R-type op 000000 {op,rs,rt,rd,5'b0,funct}: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
//   I-type {op,rs,rt,imm}: ADDI 001000, LW 100011, SW 101011, BEQ 000100 (imm passed raw, no sign ops).
//   J {000010,target}.
//  imem_addr wraps modulo 2^ADDR_W; word_count saturates at MAX_WORDS via DONE.
//  Reset mid-WRITE: strobe drops immediately (async), word not counted.
// TESTING
//  ADD rs=1 rt=2 rd=3 -> imem_wdata=0x00221820 at addr BASE_ADDR, word_count=1 after ack.
//  SLT rd=4 rs=5 rt=6 then LW rt=8 rs=29 imm=4 -> 0x00A6202A @0, 0x8FA80004 @4.
//  BEQ rs=1 rt=0 imm=FFFF, J target=0x10, imem_ack delayed 3 cycles -> 0x1020FFFF, 0x08000010;
//   we/addr/wdata stable during stall, req_ready=0 throughout.
//  kind=0xB then END -> err_illegal=1, word_count=0, done=1; next start clears err and done.
//  MAX_WORDS=2, three ADD requests -> done after 2nd ack, 3rd request never accepted (req_ready=0).
//  rst_n low while imem_we=1 -> all outputs 0 same cycle; after release, state IDLE, start required.

Source files
------------

// File: rtl/mips_instr_encoder.sv
// Symbolic MIPS instruction encoder feeding the imem write port.
// Accepts kind/field requests, encodes them and streams words out with ack handshake.
module mips_instr_encoder #(
    parameter int unsigned         ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = '0,
    parameter int unsigned         MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_kind,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic [8:0]        word_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [3:0] K_ADD  = 4'd0;
    localparam logic [3:0] K_SUB  = 4'd1;
    localparam logic [3:0] K_AND  = 4'd2;
    localparam logic [3:0] K_OR   = 4'd3;
    localparam logic [3:0] K_SLT  = 4'd4;
    localparam logic [3:0] K_ADDI = 4'd5;
    localparam logic [3:0] K_LW   = 4'd6;
    localparam logic [3:0] K_SW   = 4'd7;
    localparam logic [3:0] K_BEQ  = 4'd8;
    localparam logic [3:0] K_J    = 4'd9;
    localparam logic [3:0] K_END  = 4'd15;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [8:0] LAST_CNT = 9'(MAX_WORDS);

    state_t      state;
    logic [31:0] enc_word;
    logic        enc_legal;
    logic        enc_end;
    logic        last_word;

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        enc_end   = 1'b0;
        unique case (req_kind)
            K_ADD:  enc_word = {OP_R, req_rs, req_rt, req_rd, 5'd0, FN_ADD};
            K_SUB:  enc_word = {OP_R, req_rs, req_rt, req_rd, 5'd0, FN_SUB};
            K_AND:  enc_word = {OP_R, req_rs, req_rt, req_rd, 5'd0, FN_AND};
            K_OR:   enc_word = {OP_R, req_rs, req_rt, req_rd, 5'd0, FN_OR};
            K_SLT:  enc_word = {OP_R, req_rs, req_rt, req_rd, 5'd0, FN_SLT};
            K_ADDI: enc_word = {OP_ADDI, req_rs, req_rt, req_imm};
            K_LW:   enc_word = {OP_LW, req_rs, req_rt, req_imm};
            K_SW:   enc_word = {OP_SW, req_rs, req_rt, req_imm};
            K_BEQ:  enc_word = {OP_BEQ, req_rs, req_rt, req_imm};
            K_J:    enc_word = {OP_J, req_target};
            K_END: begin
                enc_legal = 1'b0;
                enc_end   = 1'b1;
            end
            default: enc_legal = 1'b0;
        endcase
    end

    assign last_word = (word_count + 9'd1) == LAST_CNT;

    // req_ready and busy are registered alongside state so they never glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            req_ready   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_illegal <= 1'b0;
            imem_we     <= 1'b0;
            imem_addr   <= BASE_ADDR;
            imem_wdata  <= '0;
            word_count  <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_ACCEPT;
                        req_ready   <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        err_illegal <= 1'b0;
                        imem_addr   <= BASE_ADDR;
                        word_count  <= '0;
                    end
                end
                S_ACCEPT: begin
                    if (req_valid) begin
                        if (enc_end) begin
                            state     <= S_DONE;
                            req_ready <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else if (enc_legal) begin
                            state      <= S_WRITE;
                            req_ready  <= 1'b0;
                            imem_we    <= 1'b1;
                            imem_wdata <= enc_word;
                        end else begin
                            err_illegal <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (imem_ack) begin
                        imem_we    <= 1'b0;
                        imem_addr  <= imem_addr + ADDR_W'(4);
                        word_count <= word_count + 9'd1;
                        if (last_word) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_ACCEPT;
                            req_ready <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: directed literal cases plus random traffic
// checked every cycle against a spec-level model.
module tb_mips_instr_encoder;

    localparam int MAXW = 256;
    localparam int M_IDLE = 0;
    localparam int M_ACC  = 1;
    localparam int M_WR   = 2;
    localparam int M_DONE = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_kind;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic [4:0]  req_rd;
    logic [15:0] req_imm;
    logic [25:0] req_target;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_ack;
    logic        busy;
    logic        done;
    logic        err_illegal;
    logic [8:0]  word_count;

    always #5 clk = ~clk;

    mips_instr_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_kind    (req_kind),
        .req_rs      (req_rs),
        .req_rt      (req_rt),
        .req_rd      (req_rd),
        .req_imm     (req_imm),
        .req_target  (req_target),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .imem_ack    (imem_ack),
        .busy        (busy),
        .done        (done),
        .err_illegal (err_illegal),
        .word_count  (word_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    int          m_mode;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_err;
    int          m_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_enc(input int kind, input int rs, input int rt,
                                              input int rd, input int imm, input int tgt);
        int op;
        int fn;
        op = 0;
        fn = 0;
        case (kind)
            0: fn = 32;
            1: fn = 34;
            2: fn = 36;
            3: fn = 37;
            4: fn = 42;
            5: op = 8;
            6: op = 35;
            7: op = 43;
            8: op = 4;
            default: op = 2;
        endcase
        if (kind <= 4)
            return 32'(rs * (2 ** 21) + rt * (2 ** 16) + rd * (2 ** 11) + fn);
        if (kind <= 8)
            return 32'(op) * 32'h0400_0000 + 32'(rs * (2 ** 21) + rt * (2 ** 16) + imm);
        return 32'h0800_0000 + 32'(tgt);
    endfunction

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_we    = 1'b0;
        m_addr  = 32'd0;
        m_wdata = 32'd0;
        m_err   = 1'b0;
        m_count = 0;
    endtask

    task automatic model_step();
        if ((m_mode == M_IDLE || m_mode == M_DONE) && start) begin
            m_mode  = M_ACC;
            m_addr  = 32'd0;
            m_count = 0;
            m_err   = 1'b0;
        end else if (m_mode == M_ACC && req_valid) begin
            if (int'(req_kind) <= 9) begin
                m_wdata = model_enc(int'(req_kind), int'(req_rs), int'(req_rt),
                                    int'(req_rd), int'(req_imm), int'(req_target));
                m_we    = 1'b1;
                m_mode  = M_WR;
            end else if (int'(req_kind) == 15) begin
                m_mode = M_DONE;
            end else begin
                m_err = 1'b1;
            end
        end else if (m_mode == M_WR && imem_ack) begin
            m_we    = 1'b0;
            m_addr  = m_addr + 32'd4;
            m_count = m_count + 1;
            m_mode  = (m_count == MAXW) ? M_DONE : M_ACC;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("we", 32'(imem_we), 32'(m_we));
            chk("addr", imem_addr, m_addr);
            chk("wdata", imem_wdata, m_wdata);
            chk("ready", 32'(req_ready), 32'(m_mode == M_ACC));
            chk("busy", 32'(busy), 32'(m_mode == M_ACC || m_mode == M_WR));
            chk("done", 32'(done), 32'(m_mode == M_DONE));
            chk("err", 32'(err_illegal), 32'(m_err));
            chk("count", 32'(word_count), 32'(m_count));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        if (rst_n) model_step();
    endtask

    task automatic set_req(input int kind, input int rs, input int rt, input int rd,
                           input int imm, input int tgt);
        req_kind   = 4'(kind);
        req_rs     = 5'(rs);
        req_rt     = 5'(rt);
        req_rd     = 5'(rd);
        req_imm    = 16'(imm);
        req_target = 26'(tgt);
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    // Presents a request for one accept cycle, then acks after ack_delay stall cycles
    task automatic send(input int kind, input int rs, input int rt, input int rd,
                        input int imm, input int tgt, input int ack_delay);
        int n;
        n = 0;
        while (m_mode != M_ACC && n < 20) begin
            cycle();
            n++;
        end
        chk("wait_ready", 32'(req_ready), 32'd1);
        set_req(kind, rs, rt, rd, imm, tgt);
        req_valid = 1'b1;
        cycle();
        req_valid = 1'b0;
        if (m_mode == M_WR) begin
            repeat (ack_delay) cycle();
            imem_ack = 1'b1;
            cycle();
            imem_ack = 1'b0;
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        start     = 1'b0;
        req_valid = 1'b0;
        imem_ack  = 1'b0;
        set_req(0, 0, 0, 0, 0, 0);

        chk("lit_add", model_enc(0, 1, 2, 3, 0, 0), 32'h0022_1820);
        chk("lit_slt", model_enc(4, 5, 6, 4, 0, 0), 32'h00A6_202A);
        chk("lit_lw", model_enc(6, 29, 8, 0, 4, 0), 32'h8FA8_0004);
        chk("lit_beq", model_enc(8, 1, 0, 0, 16'hFFFF, 0), 32'h1020_FFFF);
        chk("lit_j", model_enc(9, 0, 0, 0, 0, 26'h10), 32'h0800_0010);

        #3 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_count", 32'(word_count), 32'd0);
        chk_en = 1'b1;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("idle_ready", 32'(req_ready), 32'd0);

        // ADD with ack in first WRITE cycle
        do_start();
        set_req(0, 1, 2, 3, 0, 0);
        req_valid = 1'b1;
        cycle();
        req_valid = 1'b0;
        chk("add_word", imem_wdata, 32'h0022_1820);
        chk("add_addr", imem_addr, 32'd0);
        chk("add_we", 32'(imem_we), 32'd1);
        imem_ack = 1'b1;
        cycle();
        imem_ack = 1'b0;
        chk("add_count", 32'(word_count), 32'd1);

        // SLT then LW from a fresh program
        send(15, 0, 0, 0, 0, 0, 0);
        do_start();
        send(4, 5, 6, 4, 0, 0, 0);
        set_req(6, 29, 8, 0, 4, 0);
        req_valid = 1'b1;
        cycle();
        req_valid = 1'b0;
        chk("lw_word", imem_wdata, 32'h8FA8_0004);
        chk("lw_addr", imem_addr, 32'd4);
        imem_ack = 1'b1;
        cycle();
        imem_ack = 1'b0;

        // BEQ and J with a 3-cycle ack stall
        set_req(8, 1, 0, 0, 16'hFFFF, 0);
        req_valid = 1'b1;
        cycle();
        req_valid = 1'b0;
        repeat (3) begin
            cycle();
            chk("stall_ready", 32'(req_ready), 32'd0);
            chk("stall_word", imem_wdata, 32'h1020_FFFF);
        end
        imem_ack = 1'b1;
        cycle();
        imem_ack = 1'b0;
        send(9, 0, 0, 0, 0, 26'h10, 3);
        chk("j_count", 32'(word_count), 32'd4);
        chk("j_addr", imem_addr, 32'd16);

        // illegal then END
        send(15, 0, 0, 0, 0, 0, 0);
        do_start();
        send(11, 1, 1, 1, 1, 1, 0);
        send(15, 0, 0, 0, 0, 0, 0);
        chk("ill_err", 32'(err_illegal), 32'd1);
        chk("ill_count", 32'(word_count), 32'd0);
        chk("ill_done", 32'(done), 32'd1);
        do_start();
        chk("clr_err", 32'(err_illegal), 32'd0);
        chk("clr_done", 32'(done), 32'd0);

        // fill to MAX_WORDS
        for (int i = 0; i < MAXW; i++)
            send(0, i % 32, (i + 1) % 32, (i + 2) % 32, 0, 0, i % 2);
        chk("full_done", 32'(done), 32'd1);
        chk("full_count", 32'(word_count), 32'd256);
        chk("full_addr", imem_addr, 32'd1024);
        set_req(0, 1, 2, 3, 0, 0);
        req_valid = 1'b1;
        repeat (4) begin
            cycle();
            chk("full_ready", 32'(req_ready), 32'd0);
            chk("full_we", 32'(imem_we), 32'd0);
        end
        req_valid = 1'b0;

        // async reset while a write is outstanding
        do_start();
        send(1, 3, 4, 5, 0, 0, 0);
        set_req(5, 7, 8, 0, 16'h1234, 0);
        req_valid = 1'b1;
        cycle();
        req_valid = 1'b0;
        chk("pre_rst_we", 32'(imem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_we", 32'(imem_we), 32'd0);
        chk("arst_addr", imem_addr, 32'd0);
        chk("arst_count", 32'(word_count), 32'd0);
        chk("arst_wdata", imem_wdata, 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        imem_ack = 1'b1;
        cycle();
        imem_ack = 1'b0;
        rst_n = 1'b1;
        set_req(0, 1, 1, 1, 0, 0);
        req_valid = 1'b1;
        repeat (3) cycle();
        req_valid = 1'b0;
        chk("post_rst_ready", 32'(req_ready), 32'd0);
        chk("post_rst_count", 32'(word_count), 32'd0);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            start     = ($urandom_range(0, 39) == 0);
            req_valid = ($urandom_range(0, 1) == 1);
            imem_ack  = ($urandom_range(0, 2) == 0);
            set_req((r < 90) ? r % 10 : (r < 99) ? 10 + r % 5 : 15,
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 65535)),
                    int'($urandom & 32'h03FF_FFFF));
            cycle();
        end
        start     = 1'b0;
        req_valid = 1'b0;
        imem_ack  = 1'b0;
        cycle();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
